// File: rtl/solve_sequencer.sv
//============================================================================
// Module      : solve_sequencer
// Description : Step sequencer for the 4x4 klotski solver. Walks a fixed
//               22-entry placement plan, issuing one tile-mover command per
//               step, carrying board and lock mask between steps, and
//               reporting completion, solved status and a per-step timeout.
// Revision    : 1.0 - initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module solve_sequencer #(
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_start,
    input  logic [3:0][3:0][3:0]   i_klotski,
    output logic                   o_mn_start,
    output logic [3:0][3:0][3:0]   o_mn_klotski,
    output logic [3:0][3:0]        o_mn_mask,
    output logic [1:0][1:0]        o_mn_target,
    output logic [3:0]             o_mn_number,
    output logic                   o_mn_flag,
    input  logic [3:0][3:0][3:0]   i_mn_klotski,
    input  logic [3:0][3:0]        i_mn_mask,
    input  logic                   i_mn_finished,
    output logic [3:0][3:0][3:0]   o_klotski,
    output logic [4:0]             o_step,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_solved,
    output logic                   o_timeout
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_ISSUE = 3'd2;
    localparam logic [2:0] ST_WAIT  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;
    localparam logic [2:0] ST_FAIL  = 3'd5;

    localparam logic [4:0]  LAST_STEP = 5'd21;
    localparam logic [23:0] WD_LIMIT  = 24'(TIMEOUT_CYCLES - 1);

    logic [2:0]            state;
    logic [3:0][3:0][3:0]  board;
    logic [3:0][3:0]       mask;
    logic [4:0]            step;
    logic [23:0]           watchdog;

    // Plan entry layout: {number[3:0], row[1:0], col[1:0], leave_unlocked}
    logic [8:0]            rom_entry;
    logic [3:0][3:0][3:0]  goal;
    logic                  at_goal;

    // Fixed placement plan: top two rows in pairs, then the left columns of
    // the bottom half, finishing with tiles 12 and 11.
    always_comb begin
        rom_entry = '0;
        case (step)
            5'd0:    rom_entry = {4'd1,  2'd0, 2'd0, 1'b0};
            5'd1:    rom_entry = {4'd2,  2'd0, 2'd1, 1'b0};
            5'd2:    rom_entry = {4'd4,  2'd0, 2'd2, 1'b1};
            5'd3:    rom_entry = {4'd3,  2'd1, 2'd2, 1'b1};
            5'd4:    rom_entry = {4'd4,  2'd0, 2'd3, 1'b0};
            5'd5:    rom_entry = {4'd3,  2'd0, 2'd2, 1'b0};
            5'd6:    rom_entry = {4'd5,  2'd1, 2'd0, 1'b0};
            5'd7:    rom_entry = {4'd6,  2'd1, 2'd1, 1'b0};
            5'd8:    rom_entry = {4'd8,  2'd1, 2'd2, 1'b1};
            5'd9:    rom_entry = {4'd7,  2'd2, 2'd2, 1'b1};
            5'd10:   rom_entry = {4'd8,  2'd1, 2'd3, 1'b0};
            5'd11:   rom_entry = {4'd7,  2'd1, 2'd2, 1'b0};
            5'd12:   rom_entry = {4'd13, 2'd2, 2'd0, 1'b1};
            5'd13:   rom_entry = {4'd9,  2'd2, 2'd1, 1'b1};
            5'd14:   rom_entry = {4'd13, 2'd3, 2'd0, 1'b0};
            5'd15:   rom_entry = {4'd9,  2'd2, 2'd0, 1'b0};
            5'd16:   rom_entry = {4'd14, 2'd2, 2'd1, 1'b1};
            5'd17:   rom_entry = {4'd10, 2'd2, 2'd2, 1'b1};
            5'd18:   rom_entry = {4'd14, 2'd3, 2'd1, 1'b0};
            5'd19:   rom_entry = {4'd10, 2'd2, 2'd1, 1'b0};
            5'd20:   rom_entry = {4'd12, 2'd2, 2'd3, 1'b0};
            5'd21:   rom_entry = {4'd11, 2'd2, 2'd2, 1'b0};
            default: rom_entry = '0;
        endcase
    end

    // Goal board: tiles 1..15 in row-major order, blank in the last cell
    for (genvar r = 0; r < 4; r++) begin : g_goal_row
        for (genvar c = 0; c < 4; c++) begin : g_goal_col
            assign goal[r][c] = ((r == 3) && (c == 3)) ? 4'd0 : 4'(4 * r + c + 1);
        end
    end

    assign at_goal      = (board == goal);
    assign o_mn_klotski = board;
    assign o_mn_mask    = mask;
    assign o_klotski    = board;
    assign o_step       = step;

    // Sequencer state machine with registered command and status outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= ST_IDLE;
            board       <= '0;
            mask        <= '0;
            step        <= '0;
            watchdog    <= '0;
            o_mn_start  <= 1'b0;
            o_mn_target <= '0;
            o_mn_number <= '0;
            o_mn_flag   <= 1'b0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_solved    <= 1'b0;
            o_timeout   <= 1'b0;
        end else begin
            o_mn_start <= 1'b0;
            o_done     <= 1'b0;
            o_timeout  <= 1'b0;
            o_busy     <= (state == ST_LOAD) || (state == ST_ISSUE) || (state == ST_WAIT);
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    board <= i_klotski;
                    mask  <= '0;
                    step  <= '0;
                    state <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    o_mn_number <= rom_entry[8:5];
                    o_mn_target <= rom_entry[4:1];
                    o_mn_flag   <= rom_entry[0];
                    o_mn_start  <= 1'b1;
                    watchdog    <= '0;
                    state       <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A finish arriving on the expiry cycle still counts
                    if (i_mn_finished) begin
                        board <= i_mn_klotski;
                        mask  <= i_mn_mask;
                        if (step == LAST_STEP) begin
                            state <= ST_DONE;
                        end else begin
                            step  <= step + 5'd1;
                            state <= ST_ISSUE;
                        end
                    end else if (watchdog == WD_LIMIT) begin
                        state <= ST_FAIL;
                    end else if (watchdog != '1) begin
                        watchdog <= watchdog + 24'd1;
                    end
                end
                ST_DONE: begin
                    o_done   <= 1'b1;
                    o_solved <= at_goal;
                    state    <= ST_IDLE;
                end
                ST_FAIL: begin
                    // Board and step are left untouched for post-mortem
                    o_timeout <= 1'b1;
                    o_solved  <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_solve_sequencer.sv
//============================================================================
// Module      : tb_solve_sequencer
// Description : Self-checking bench for solve_sequencer with a behavioural
//               tile-mover model and plan/goal reference tables.
// Revision    : 1.0 - initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_solve_sequencer;

    localparam int T = 100;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  start = 1'b0;
    logic [3:0][3:0][3:0]  klotski = '0;
    logic                  mn_start;
    logic [3:0][3:0][3:0]  mn_klotski_o;
    logic [3:0][3:0]       mn_mask_o;
    logic [1:0][1:0]       mn_target;
    logic [3:0]            mn_number;
    logic                  mn_flag;
    logic [3:0][3:0][3:0]  mn_klotski_i = '0;
    logic [3:0][3:0]       mn_mask_i = '0;
    logic                  mn_finished = 1'b0;
    logic [3:0][3:0][3:0]  board_o;
    logic [4:0]            step_o;
    logic                  busy, done, solved, timeout;

    int checks = 0;
    int errors = 0;
    logic [63:0] last_board = '0;

    int plan_num[22] = '{1,2,4,3,4,3,5,6,8,7,8,7,13,9,13,9,14,10,14,10,12,11};
    int plan_row[22] = '{0,0,0,1,0,0,1,1,1,2,1,1,2,2,3,2,2,2,3,2,2,2};
    int plan_col[22] = '{0,1,2,2,3,2,0,1,2,2,3,2,0,1,0,0,1,2,1,1,3,2};
    int plan_unl[22] = '{0,0,1,1,0,0,0,0,1,1,0,0,1,1,0,0,1,1,0,0,0,0};

    solve_sequencer #(.TIMEOUT_CYCLES(T)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_start       (start),
        .i_klotski     (klotski),
        .o_mn_start    (mn_start),
        .o_mn_klotski  (mn_klotski_o),
        .o_mn_mask     (mn_mask_o),
        .o_mn_target   (mn_target),
        .o_mn_number   (mn_number),
        .o_mn_flag     (mn_flag),
        .i_mn_klotski  (mn_klotski_i),
        .i_mn_mask     (mn_mask_i),
        .i_mn_finished (mn_finished),
        .o_klotski     (board_o),
        .o_step        (step_o),
        .o_busy        (busy),
        .o_done        (done),
        .o_solved      (solved),
        .o_timeout     (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] goal_board();
        logic [3:0][3:0][3:0] g;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                g[r][c] = (r == 3 && c == 3) ? 4'd0 : 4'(4 * r + c + 1);
        return g;
    endfunction

    function automatic logic [63:0] rand_board();
        return {$urandom, $urandom};
    endfunction

    task automatic check_zero();
        check("z_mn_start",  64'(mn_start),     64'd0);
        check("z_mn_klot",   mn_klotski_o,      64'd0);
        check("z_mn_mask",   64'(mn_mask_o),    64'd0);
        check("z_mn_target", 64'(mn_target),    64'd0);
        check("z_mn_number", 64'(mn_number),    64'd0);
        check("z_mn_flag",   64'(mn_flag),      64'd0);
        check("z_klotski",   board_o,           64'd0);
        check("z_step",      64'(step_o),       64'd0);
        check("z_busy",      64'(busy),         64'd0);
        check("z_done",      64'(done),         64'd0);
        check("z_solved",    64'(solved),       64'd0);
        check("z_timeout",   64'(timeout),      64'd0);
    endtask

    // mode 0: mover hands the board back unchanged
    // mode 1: random intermediate boards, goal board on the last step
    // mode 2: random intermediate boards, non-goal board on the last step
    task automatic run_solve(input int lat, input int mode, input int stall_step,
                             input int rst_step, input bit poke_start, input logic [63:0] init);
        logic [63:0] exp_board, nb;
        logic [15:0] exp_mask, nm;
        int n, issues, remaining, issue_n, done_n, to_n, dones, tos, rst_at, end_n;
        exp_board = init; exp_mask = '0;
        issues = 0; remaining = -1; issue_n = 0; done_n = -1; to_n = -1;
        dones = 0; tos = 0; rst_at = -1; end_n = -1;
        klotski = init;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (n < 4000 && (end_n < 0 || n < end_n)) begin
            @(negedge clk);
            n++;
            mn_finished = 1'b0;
            start = 1'b0;
            if (n == rst_at) begin
                #2 rst_n = 1'b0;
                #1 check_zero();
                @(negedge clk);
                rst_n = 1'b1;
                last_board = '0;
                return;
            end
            if (mn_start) begin
                if (issues < 22) begin
                    check("plan_number", 64'(mn_number), 64'(plan_num[issues]));
                    check("plan_target", 64'(mn_target), 64'(plan_row[issues] * 4 + plan_col[issues]));
                    check("plan_flag",   64'(mn_flag),   64'(plan_unl[issues]));
                end
                check("issue_board", mn_klotski_o, exp_board);
                check("issue_mask",  64'(mn_mask_o), 64'(exp_mask));
                check("issue_step",  64'(step_o), 64'(issues));
                check("issue_busy",  64'(busy), 64'd1);
                issue_n = n;
                remaining = (issues == stall_step) ? -1 : lat;
                issues++;
                if (rst_step >= 0 && issues == rst_step + 1) rst_at = n + 3;
            end
            if (poke_start && issues == 5 && n == issue_n + 1) start = 1'b1;
            if (remaining == 0) begin
                remaining = -1;
                if (mode == 0) begin
                    nb = exp_board;
                    nm = exp_mask;
                end else begin
                    nb = rand_board();
                    nm = 16'($urandom);
                    if (issues == 22) begin
                        nb = goal_board();
                        if (mode == 2) nb[7:0] = 8'h12;
                    end
                end
                mn_klotski_i = nb;
                mn_mask_i = nm;
                mn_finished = 1'b1;
                exp_board = nb;
                exp_mask = nm;
            end else if (remaining > 0) begin
                remaining--;
            end
            if (done) begin
                dones++;
                if (done_n < 0) begin
                    done_n = n;
                    check("done_busy", 64'(busy), 64'd0);
                    end_n = n + 5;
                end
            end
            if (timeout) begin
                tos++;
                if (to_n < 0) begin
                    to_n = n;
                    end_n = n + 5;
                end
            end
        end
        check("run_ended", 64'(end_n >= 0), 64'd1);
        if (stall_step >= 0) begin
            check("to_count",   64'(tos), 64'd1);
            check("to_latency", 64'(to_n - issue_n), 64'(T + 1));
            check("to_step",    64'(step_o), 64'(stall_step));
            check("to_issues",  64'(issues), 64'(stall_step + 1));
            check("to_busy",    64'(busy), 64'd0);
            check("to_nodone",  64'(dones), 64'd0);
            check("to_solved",  64'(solved), 64'd0);
            check("to_board",   board_o, exp_board);
        end else begin
            check("done_count", 64'(dones), 64'd1);
            check("issues",     64'(issues), 64'd22);
            check("done_lat",   64'(done_n), 64'(2 + 22 * (lat + 2)));
            check("solved",     64'(solved), 64'(exp_board == goal_board()));
            check("final_board", board_o, exp_board);
            check("final_step", 64'(step_o), 64'd21);
            check("final_busy", 64'(busy), 64'd0);
            check("no_timeout", 64'(tos), 64'd0);
        end
        last_board = exp_board;
    endtask

    task automatic stray_idle();
        logic [4:0] step_before;
        step_before = step_o;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            mn_klotski_i = rand_board();
            mn_mask_i = 16'($urandom);
            mn_finished = 1'b1;
        end
        @(negedge clk);
        mn_finished = 1'b0;
        @(negedge clk);
        check("stray_board", board_o, last_board);
        check("stray_step",  64'(step_o), 64'(step_before));
        check("stray_start", 64'(mn_start), 64'd0);
        check("stray_busy",  64'(busy), 64'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_zero();
        rst_n = 1'b1;
        @(negedge clk);
        run_solve(10, 0, -1, -1, 1'b0, goal_board());
        stray_idle();
        run_solve($urandom_range(0, 20), 2, -1, -1, 1'b1, rand_board());
        run_solve($urandom_range(0, 20), 1, -1, -1, 1'b0, rand_board());
        run_solve(5, 1, 3, -1, 1'b0, rand_board());
        run_solve(4, 1, -1, 10, 1'b0, rand_board());
        run_solve($urandom_range(0, 20), 0, -1, -1, 1'b0, rand_board());
        for (int k = 0; k < 3; k++)
            run_solve($urandom_range(0, 20), $urandom_range(0, 2), -1, -1, 1'b0, rand_board());
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
